// File: rtl/capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : capture_ctrl_if
// Brief    : Control, sample-RAM and readout signals of the capture sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface capture_ctrl_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 12
) ();
    logic                  arm;
    logic                  abort;
    logic                  sample_valid;
    logic [DATA_WIDTH-1:0] sample_in;
    logic [DATA_WIDTH-1:0] trig_level;
    logic                  trig_rising;
    logic [ADDR_WIDTH-1:0] pretrig_depth;

    logic                  ram_we_a;
    logic [ADDR_WIDTH-1:0] ram_addr_a;
    logic [DATA_WIDTH-1:0] ram_in_a;

    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_index;
    logic [ADDR_WIDTH-1:0] ram_addr_b;
    logic                  rd_valid;

    logic                  busy;
    logic                  triggered;
    logic                  done;
    logic [ADDR_WIDTH-1:0] trig_addr;

    // Host / front-end side
    modport master (
        output arm, abort, sample_valid, sample_in, trig_level, trig_rising,
               pretrig_depth, rd_req, rd_index,
        input  ram_we_a, ram_addr_a, ram_in_a, ram_addr_b, rd_valid,
               busy, triggered, done, trig_addr
    );

    // Sequencer side
    modport slave (
        input  arm, abort, sample_valid, sample_in, trig_level, trig_rising,
               pretrig_depth, rd_req, rd_index,
        output ram_we_a, ram_addr_a, ram_in_a, ram_addr_b, rd_valid,
               busy, triggered, done, trig_addr
    );
endinterface
`default_nettype wire

// File: rtl/capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : capture_ctrl
// Brief    : Circular-buffer acquisition sequencer with level/slope trigger,
//            pre-trigger depth and logical-to-physical readout translation.
// Revision : 1.0 - initial release
// ============================================================================
module capture_ctrl #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 12
) (
    input  logic           clock,
    input  logic           reset_n,
    capture_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH:0]   c_depth    = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = 1;
    localparam logic [ADDR_WIDTH:0]   c_cnt_one  = 1;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_p;
    logic [ADDR_WIDTH-1:0] r_wp;
    logic [ADDR_WIDTH-1:0] r_pre_cnt;
    logic [ADDR_WIDTH:0]   r_post_cnt;
    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_prev_valid;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr_a;
    logic [DATA_WIDTH-1:0] r_din_a;
    logic [ADDR_WIDTH-1:0] r_addr_b;
    logic [1:0]            r_rd_pipe;
    logic                  r_busy;
    logic                  r_trig;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_trig_addr;

    logic                  w_busy_state;
    logic                  w_accept;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_trig_hit;
    logic [ADDR_WIDTH-1:0] w_pre_next;
    logic [ADDR_WIDTH:0]   w_post_next;
    logic [ADDR_WIDTH:0]   w_post_target;
    logic [ADDR_WIDTH-1:0] w_start;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_rd_accept;
    logic                  w_arm_ok;

    assign w_busy_state  = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
    assign w_accept      = w_busy_state && bus.sample_valid;
    assign w_arm_ok      = bus.arm && ((r_state == S_IDLE) || (r_state == S_DONE));

    assign w_rise        = (r_prev < bus.trig_level) && (bus.sample_in >= bus.trig_level);
    assign w_fall        = (r_prev > bus.trig_level) && (bus.sample_in <= bus.trig_level);
    assign w_trig_hit    = w_accept && r_prev_valid && (bus.trig_rising ? w_rise : w_fall);

    assign w_pre_next    = r_pre_cnt + c_addr_one;
    assign w_post_next   = r_post_cnt + c_cnt_one;
    // Post-trigger length includes the trigger sample itself; needs one extra bit for P = 0.
    assign w_post_target = c_depth - {1'b0, r_p};

    // Oldest sample of the frozen capture sits P words before the trigger.
    assign w_start       = r_trig_addr - r_p;
    assign w_rd_addr     = w_start + bus.rd_index;
    assign w_rd_accept   = (r_state == S_DONE) && bus.rd_req;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_p          <= '0;
            r_wp         <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_we         <= 1'b0;
            r_addr_a     <= '0;
            r_din_a      <= '0;
            r_addr_b     <= '0;
            r_rd_pipe    <= 2'b00;
            r_busy       <= 1'b0;
            r_trig       <= 1'b0;
            r_done       <= 1'b0;
            r_trig_addr  <= '0;
        end else begin
            r_we      <= 1'b0;
            // Address register plus one RAM read cycle before the data is usable.
            r_rd_pipe <= {r_rd_pipe[0], w_rd_accept};
            if (w_rd_accept) begin
                r_addr_b <= w_rd_addr;
            end

            if (bus.abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_trig  <= 1'b0;
                r_done  <= 1'b0;
            end else if (w_arm_ok) begin
                r_p          <= bus.pretrig_depth;
                r_wp         <= '0;
                r_pre_cnt    <= '0;
                r_post_cnt   <= '0;
                r_prev_valid <= 1'b0;
                r_busy       <= 1'b1;
                r_trig       <= 1'b0;
                r_done       <= 1'b0;
                r_state      <= (bus.pretrig_depth != '0) ? S_PRE : S_WAIT;
            end else if (w_accept) begin
                r_we         <= 1'b1;
                r_addr_a     <= r_wp;
                r_din_a      <= bus.sample_in;
                r_wp         <= r_wp + c_addr_one;
                r_prev       <= bus.sample_in;
                r_prev_valid <= 1'b1;

                case (r_state)
                    S_PRE: begin
                        r_pre_cnt <= w_pre_next;
                        if (w_pre_next == r_p) begin
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (w_trig_hit) begin
                            r_trig_addr <= r_wp;
                            r_post_cnt  <= c_cnt_one;
                            r_trig      <= 1'b1;
                            if (w_post_target == c_cnt_one) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        r_post_cnt <= w_post_next;
                        if (w_post_next == w_post_target) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.ram_we_a   = r_we;
    assign bus.ram_addr_a = r_addr_a;
    assign bus.ram_in_a   = r_din_a;
    assign bus.ram_addr_b = r_addr_b;
    assign bus.rd_valid   = r_rd_pipe[1];
    assign bus.busy       = r_busy;
    assign bus.triggered  = r_trig;
    assign bus.done       = r_done;
    assign bus.trig_addr  = r_trig_addr;

endmodule
`default_nettype wire
